// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) peripheral-side shift engine.
// The external sck/ss/mosi pins are synchronized into the clk domain.
// Words are received MSB-first, and a user-supplied word is shifted out on miso at the same time.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   rst      synchronous reset, active-high
//   ss       slave select pin, active-low, asynchronous
//   sck      serial clock pin, asynchronous
//   mosi     serial data in pin, asynchronous
//   miso     serial data out, registered (1 while deselected)
//   data_in  word to transmit, sampled at ss fall and at the first fall after a word completes
//   data_out last complete received word, registered
//   new_data one-clk pulse when data_out updates
//   busy     high while a selected transfer window is active
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             new_data,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [1:0]       ss_sync_r;
  logic [1:0]       sck_sync_r;
  logic [1:0]       mosi_sync_r;
  logic             ss_s;
  logic             sck_s;
  logic             mosi_s;
  logic             sck_d_r;
  logic             ss_d_r;
  logic             rise_s;
  logic             fall_s;
  logic             ss_fall_s;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             miso_nxt_s;
  logic             busy_nxt_s;

  logic [CNT_W-1:0] bit_cnt_r;
  logic [WIDTH-1:0] rx_shift_r;
  logic [WIDTH-1:0] tx_shift_r;
  logic [WIDTH-1:0] rx_nxt_s;
  logic             word_done_r;

  assign ss_s      = ss_sync_r[1];
  assign sck_s     = sck_sync_r[1];
  assign mosi_s    = mosi_sync_r[1];
  assign rise_s    = sck_s & ~sck_d_r;
  assign fall_s    = ~sck_s & sck_d_r;
  assign ss_fall_s = ~ss_s & ss_d_r;
  assign rx_nxt_s  = {rx_shift_r[WIDTH-2:0], mosi_s};

  // Two-flop pin synchronizers plus the edge-detect delay flops.
  // The ss path resets to 0 so that a slave select which is already low when rst drops cannot look like a fresh ss fall.
  // That transfer stays ignored until ss goes high and then low again.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync_r   <= 2'b00;
      sck_sync_r  <= 2'b00;
      mosi_sync_r <= 2'b00;
      sck_d_r     <= 1'b0;
      ss_d_r      <= 1'b0;
    end else begin
      ss_sync_r   <= {ss_sync_r[0], ss};
      sck_sync_r  <= {sck_sync_r[0], sck};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      sck_d_r     <= sck_s;
      ss_d_r      <= ss_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: enter ACTIVE only on a genuine ss fall, leave as soon as ss is high.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ss_fall_s) begin
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (ss_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: drive the tx MSB while selected, otherwise idle-high.
  always_comb begin
    miso_nxt_s = 1'b1;
    busy_nxt_s = 1'b0;
    case (state_r)
      ACTIVE: begin
        miso_nxt_s = tx_shift_r[WIDTH-1];
        busy_nxt_s = 1'b1;
      end
      IDLE: begin
        miso_nxt_s = 1'b1;
        busy_nxt_s = 1'b0;
      end
      default: begin
        miso_nxt_s = 1'b1;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Shift datapath and registered outputs.
  // word_done_r defers the tx reload to the first sck fall after a word completes, which gives the user time to update data_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso        <= 1'b1;
      busy        <= 1'b0;
      data_out    <= '0;
      new_data    <= 1'b0;
      bit_cnt_r   <= '0;
      rx_shift_r  <= '0;
      tx_shift_r  <= '0;
      word_done_r <= 1'b0;
    end else begin
      miso     <= miso_nxt_s;
      busy     <= busy_nxt_s;
      new_data <= 1'b0;
      if (ss_s) begin
        // Deselected: drop any partial word.
        bit_cnt_r   <= '0;
        rx_shift_r  <= '0;
        word_done_r <= 1'b0;
      end else if (ss_fall_s) begin
        tx_shift_r  <= data_in;
        bit_cnt_r   <= '0;
        word_done_r <= 1'b0;
      end else if (state_r == ACTIVE) begin
        if (rise_s) begin
          rx_shift_r <= rx_nxt_s;
          if (bit_cnt_r == LAST_CNT) begin
            data_out    <= rx_nxt_s;
            new_data    <= 1'b1;
            bit_cnt_r   <= '0;
            word_done_r <= 1'b1;
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
        end else if (fall_s) begin
          if (word_done_r) begin
            tx_shift_r  <= data_in;
            word_done_r <= 1'b0;
          end else begin
            tx_shift_r <= {tx_shift_r[WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave (WIDTH=8).
// Received words are checked against a queue of expected words.
// An expected word is pushed when the master starts sending it, and it is popped when new_data is seen.
// The miso word is rebuilt from samples taken just before each sck rise.
module tb_spi_slave;

  logic       clk;
  logic       rst;
  logic       ss;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       new_data;
  logic       busy;

  int         checks;
  int         errors;
  int         pulses;
  logic       prev_nd;
  logic [7:0] exp_q[$];
  logic [7:0] miso_word;
  logic [31:0] rnd;

  spi_slave #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .data_in  (data_in),
    .data_out (data_out),
    .new_data (new_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  task automatic checkint(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance n clocks. After each edge, sample new_data 1 time unit later and score any pulse against the queue.
  task automatic tick(input int n);
    logic [7:0] expw;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_nd = 1'b0;
      end else begin
        if (new_data) begin
          pulses++;
          check1("new_data_single_cycle", prev_nd, 1'b0);
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_new_data observed=%02h expected=none", data_out);
          end
          if (exp_q.size() != 0) begin
            expw = exp_q.pop_front();
            check8("scoreboard_data_out", data_out, expw);
          end
        end
        prev_nd = new_data;
      end
    end
  endtask

  // Master side of one mode-0 word (nbits bits, 4-clk phases).
  // If upd is set, data_in is changed to nv 1 clk after the new_data pulse.
  task automatic send_word(input logic [7:0] tx, input int nbits, input logic upd,
                           input logic [7:0] nv, output logic [7:0] rx_miso);
    logic pending;
    pending = 1'b0;
    rx_miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(4);
      rx_miso = {rx_miso[6:0], miso};
      sck = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick(1);
        if (pending) begin
          data_in = nv;
          pending = 1'b0;
        end else if (upd && new_data) begin
          pending = 1'b1;
        end
      end
      sck = 1'b0;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    pulses  = 0;
    prev_nd = 1'b0;
    rst     = 1'b1;
    ss      = 1'b1;
    sck     = 1'b0;
    mosi    = 1'b0;
    data_in = 8'h00;

    // 1. Reset
    tick(5);
    check8("reset_data_out", data_out, 8'h00);
    check1("reset_new_data", new_data, 1'b0);
    check1("reset_miso", miso, 1'b1);
    check1("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick(8);
    check1("idle_miso", miso, 1'b1);

    // 2. Single word
    data_in = 8'hB7;
    exp_q.push_back(8'hA5);
    ss = 1'b0;
    tick(8);
    check1("busy_during_ss_low", busy, 1'b1);
    send_word(8'hA5, 8, 1'b0, 8'h00, miso_word);
    check8("single_miso_word", miso_word, 8'hB7);
    tick(4);
    check1("busy_before_ss_rise", busy, 1'b1);
    ss = 1'b1;
    tick(8);
    check1("busy_after_ss_rise", busy, 1'b0);
    checkint("single_pulse_count", pulses, 1);
    check8("single_data_out", data_out, 8'hA5);

    // 3. Back-to-back words with ss held low
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h81);
    ss = 1'b0;
    tick(8);
    send_word(8'h3C, 8, 1'b1, 8'hED, miso_word);
    check8("b2b_miso_word0", miso_word, 8'hB7);
    check8("b2b_data_out0", data_out, 8'h3C);
    send_word(8'h81, 8, 1'b0, 8'h00, miso_word);
    check8("b2b_miso_word1", miso_word, 8'hED);
    tick(4);
    ss = 1'b1;
    tick(8);
    checkint("b2b_pulse_count", pulses, 3);
    check8("b2b_data_out1", data_out, 8'h81);

    // 4. Abort after 5 bits, then recover
    ss = 1'b0;
    tick(8);
    send_word(8'hFF, 5, 1'b0, 8'h00, miso_word);
    tick(4);
    ss = 1'b1;
    tick(8);
    checkint("abort_pulse_count", pulses, 3);
    check8("abort_data_out_held", data_out, 8'h81);
    check1("abort_miso_idle", miso, 1'b1);
    data_in = 8'h96;
    exp_q.push_back(8'h5A);
    ss = 1'b0;
    tick(8);
    send_word(8'h5A, 8, 1'b0, 8'h00, miso_word);
    check8("recover_miso_word", miso_word, 8'h96);
    tick(4);
    ss = 1'b1;
    tick(8);
    checkint("recover_pulse_count", pulses, 4);
    check8("recover_data_out", data_out, 8'h5A);

    // 5. sck noise while deselected
    for (int t = 0; t < 16; t++) begin
      rnd  = $urandom;
      mosi = rnd[0];
      sck  = ~sck;
      tick(4);
      check1("noise_miso", miso, 1'b1);
    end
    tick(4);
    checkint("noise_pulse_count", pulses, 4);
    check8("noise_data_out", data_out, 8'h5A);
    check1("noise_busy", busy, 1'b0);

    // 6. Reset mid-word, then a clean transfer
    ss = 1'b0;
    tick(8);
    send_word(8'hF0, 3, 1'b0, 8'h00, miso_word);
    rst = 1'b1;
    tick(2);
    check8("midrst_data_out", data_out, 8'h00);
    check1("midrst_new_data", new_data, 1'b0);
    check1("midrst_miso", miso, 1'b1);
    check1("midrst_busy", busy, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(8);
    ss = 1'b1;
    tick(8);
    data_in = 8'h4E;
    exp_q.push_back(8'hC3);
    ss = 1'b0;
    tick(8);
    send_word(8'hC3, 8, 1'b0, 8'h00, miso_word);
    check8("postrst_miso_word", miso_word, 8'h4E);
    tick(4);
    ss = 1'b1;
    tick(8);
    checkint("postrst_pulse_count", pulses, 5);
    check8("postrst_data_out", data_out, 8'hC3);
    checkint("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
